step_counter: RTL and testbench

Parametrised registered up/down step counter for the ALU datapath. It generalises the 4-bit enabled decrement stage to N bits, a programmable step, both directions, synchronous load and registered borrow/carry and terminal flags. It sits beside the ALU function units and supplies loop or index values, either as a stand-alone counter or as the registered form of the increment/decrement functions.

---
 rtl/alu_pkg.sv | 6 +
 rtl/step_addsub.sv | 17 +
 rtl/step_counter.sv | 77 +++++++
 tb/tb_step_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: count direction encoding and default datapath width.
package alu_pkg;
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;
   localparam int   ALU_W    = 4;
endpackage

// File: rtl/step_addsub.sv
// Generalised add/subtract stage: {cout, y} = a + b (up) or a - b (down).
// When subtracting, cout is the borrow out of the top bit.
module step_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             dir,
   output logic [WIDTH:0]   y
);
   always_comb begin
      if (dir == DIR_UP) y = {1'b0, a} + {1'b0, b};
      else               y = {1'b0, a} - {1'b0, b};
   end
endmodule

// File: rtl/step_counter.sv
// Registered up/down step counter with load, carry/borrow pulse and terminal flags.
// Optional saturating mode is built in when ALU_CNT_SAT_EN is defined.
module step_counter
   import alu_pkg::*;
#(
   parameter int               WIDTH   = ALU_W,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             dir,
   input  logic [WIDTH-1:0] step,
   input  logic             sat,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             tc,
   output logic             cb,
   output logic             sat_hit
);
   logic [WIDTH:0]   res;
   logic             sat_mode;
   logic [WIDTH-1:0] q_nxt;
   logic             cb_nxt;
   logic             sat_hit_nxt;

   step_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (q),
      .b   (step),
      .dir (dir),
      .y   (res)
   );

`ifdef ALU_CNT_SAT_EN
   assign sat_mode = sat;
`else
   logic unused_sat;
   assign unused_sat = sat;
   assign sat_mode   = 1'b0;
`endif

   always_comb begin
      q_nxt       = q;
      cb_nxt      = 1'b0;
      sat_hit_nxt = 1'b0;
      if (load) begin
         q_nxt = d;
      end else if (en) begin
         // The out-of-range bit doubles as the clamp trigger in saturate mode.
         if (sat_mode && res[WIDTH]) begin
            q_nxt       = (dir == DIR_UP) ? '1 : '0;
            sat_hit_nxt = 1'b1;
         end else begin
            q_nxt  = res[WIDTH-1:0];
            cb_nxt = res[WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= RST_VAL;
         zero    <= (RST_VAL == '0);
         cb      <= 1'b0;
         sat_hit <= 1'b0;
      end else begin
         q       <= q_nxt;
         zero    <= (q_nxt == '0);
         cb      <= cb_nxt;
         sat_hit <= sat_hit_nxt;
      end
   end

   assign tc = (dir == DIR_DOWN) ? (q == '0) : (q == '1);
endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter (WIDTH=4, RST_VAL=5); expectations follow ALU_CNT_SAT_EN.
module tb_step_counter;
   localparam int W = 4;
   localparam logic [W-1:0] RV = 4'd5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] d = '0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] step = '0;
   logic         sat = 1'b0;
   logic [W-1:0] q;
   logic         zero, tc, cb, sat_hit;

   int checks = 0;
   int failures = 0;

   step_counter #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .d(d), .en(en), .dir(dir),
      .step(step), .sat(sat), .q(q), .zero(zero), .tc(tc), .cb(cb), .sat_hit(sat_hit)
   );

   always #5 clk = ~clk;

`ifdef ALU_CNT_SAT_EN
   localparam bit SAT_BUILD = 1'b1;
`else
   localparam bit SAT_BUILD = 1'b0;
`endif

   // Behavioural model: integer arithmetic, out-of-range detected by comparing against 0..2^W-1.
   logic [W-1:0] mq;
   logic         mcb, msh;

   function automatic int raw_next(input logic [W-1:0] cur, input logic up, input logic [W-1:0] stp);
      return up ? int'(cur) + int'(stp) : int'(cur) - int'(stp);
   endfunction

   function automatic logic [W-1:0] modw(input int r);
      return W'((r + (1 << W)) % (1 << W));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq  <= RV;
         mcb <= 1'b0;
         msh <= 1'b0;
      end else if (load) begin
         mq  <= d;
         mcb <= 1'b0;
         msh <= 1'b0;
      end else if (en) begin
         if (raw_next(mq, dir, step) < 0 || raw_next(mq, dir, step) >= (1 << W)) begin
            if (SAT_BUILD && sat) begin
               mq  <= dir ? {W{1'b1}} : '0;
               msh <= 1'b1;
               mcb <= 1'b0;
            end else begin
               mq  <= modw(raw_next(mq, dir, step));
               mcb <= 1'b1;
               msh <= 1'b0;
            end
         end else begin
            mq  <= modw(raw_next(mq, dir, step));
            mcb <= 1'b0;
            msh <= 1'b0;
         end
      end else begin
         mcb <= 1'b0;
         msh <= 1'b0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_q", int'(q), int'(mq));
      chk("model_zero", int'(zero), int'(mq == '0));
      chk("model_tc", int'(tc), int'(dir ? (mq == {W{1'b1}}) : (mq == '0)));
      chk("model_cb", int'(cb), int'(mcb));
      chk("model_sat_hit", int'(sat_hit), int'(msh));
   end

   // Apply one cycle of inputs, return 1 time unit after the sampling edge.
   task automatic drive(input logic l, input logic [W-1:0] dv, input logic e,
                        input logic dr, input logic [W-1:0] s, input logic st);
      load = l; d = dv; en = e; dir = dr; step = s; sat = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_q", int'(q), 5);
      chk("rst_zero", int'(zero), 0);
      chk("rst_cb", int'(cb), 0);
      chk("rst_sat_hit", int'(sat_hit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("hold_after_rst", int'(q), 5);

      // Wrap down through zero
      drive(1, 4'b0010, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0);
      chk("wd1_q", int'(q), 1);
      chk("wd1_cb", int'(cb), 0);
      drive(0, 0, 1, 0, 1, 0);
      chk("wd2_q", int'(q), 0);
      chk("wd2_zero", int'(zero), 1);
      chk("wd2_cb", int'(cb), 0);
      drive(0, 0, 1, 0, 1, 0);
      chk("wd3_q", int'(q), 15);
      chk("wd3_cb", int'(cb), 1);
      chk("wd3_zero", int'(zero), 0);

      // Wrap up by three
      drive(1, 4'b1100, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 3, 0);
      chk("wu1_q", int'(q), 15);
      chk("wu1_tc", int'(tc), 1);
      chk("wu1_cb", int'(cb), 0);
      drive(0, 0, 1, 1, 3, 0);
      chk("wu2_q", int'(q), 2);
      chk("wu2_cb", int'(cb), 1);

      // Saturate stimulus
      drive(1, 4'b0001, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 4, 1);
      chk("sat1_q", int'(q), SAT_BUILD ? 0 : 13);
      chk("sat1_hit", int'(sat_hit), SAT_BUILD ? 1 : 0);
      chk("sat1_cb", int'(cb), SAT_BUILD ? 0 : 1);
      drive(0, 0, 1, 0, 4, 1);
      chk("sat2_q", int'(q), SAT_BUILD ? 0 : 9);
      chk("sat2_hit", int'(sat_hit), SAT_BUILD ? 1 : 0);
      drive(0, 0, 0, 0, 0, 1);
      chk("sat_idle_hit", int'(sat_hit), 0);

      // Load beats enable; step 0 holds
      drive(1, 4'b1010, 1, 1, 1, 0);
      chk("prio_q", int'(q), 10);
      chk("prio_cb", int'(cb), 0);
      drive(0, 0, 1, 1, 0, 0);
      chk("step0_q", int'(q), 10);
      chk("step0_cb", int'(cb), 0);

      // Direction change only affects tc
      drive(1, 4'b1111, 0, 0, 0, 0);
      chk("dir0_tc", int'(tc), 0);
      dir = 1'b1;
      #1;
      chk("dir1_tc", int'(tc), 1);
      chk("dir1_q", int'(q), 15);

      // Mixed table, checked against the model each cycle
      drive(1, 4'd7, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++)
         drive(0, 0, 1, logic'(i % 3 == 0), W'(i + 2), logic'(i[1]));

      // Async reset between edges while counting
      drive(1, 4'd9, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 1, 0);
      chk("pre_arst_q", int'(q), 10);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_q", int'(q), 5);
      chk("arst_cb", int'(cb), 0);
      @(posedge clk);
      #1;
      chk("arst_hold_q", int'(q), 5);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 1, 1, 1, 0);
      chk("post_arst_q", int'(q), 6);
      drive(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
